// File: rtl/decoder_hold.sv
// decoder_hold: accepts a 3-bit Code through a ready/valid handshake and drives
// the matching one-hot word on Data for HOLD_CYCLES cycles. Data then returns to
// zero for GAP_CYCLES cycles before the next Code can be accepted. A one-cycle
// done pulse marks the end of every hold.
// Optional build macro DECODER_PARITY_EN adds an even-parity check on Code
// through code_par. A failed check reports par_err instead of decoding.
module decoder_hold #(
    parameter int HOLD_CYCLES = 4,  // 1..255
    parameter int GAP_CYCLES  = 1   // 0..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] Code,
    input  logic       in_valid,
`ifdef DECODER_PARITY_EN
    input  logic       code_par,
    output logic       par_err,
`endif
    output logic       in_ready,
    output logic [7:0] Data,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    // The counter holds "cycles left after this one", so each phase loads N-1.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD  = 8'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    state_t     state, state_d;
    logic [7:0] cnt, cnt_d;
    logic [7:0] data_d;
    logic       done_d;
    logic       xfer;
    logic       par_ok;

    // Ready depends only on the registered state, and is held low while reset is asserted.
    assign in_ready = (state == IDLE) && !rst;
    assign xfer     = in_valid && in_ready;
    assign busy     = (state != IDLE);

`ifdef DECODER_PARITY_EN
    logic par_err_d;
    // The Code bits and code_par together must have an even number of ones.
    assign par_ok = ~^{Code, code_par};
`else
    assign par_ok = 1'b1;
`endif

    // Next-state and next-output logic. All outputs are registered from these values.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave it unassigned and infer a latch.
        state_d = state;
        cnt_d   = cnt;
        data_d  = Data;
        done_d  = 1'b0;
`ifdef DECODER_PARITY_EN
        par_err_d = xfer && !par_ok;
`endif
        case (state)
            IDLE: begin
                if (xfer && par_ok) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                    data_d  = 8'd1 << Code;
                end
            end
            HOLD: begin
                if (cnt == 8'd0) begin
                    data_d = 8'd0;
                    done_d = 1'b1;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            GAP: begin
                data_d = 8'd0;
                if (cnt == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
                data_d  = 8'd0;
            end
        endcase
    end

    // State, counter and output registers. Reset clears them asynchronously, including any hold in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
            Data  <= 8'd0;
            done  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make all registers update together from pre-edge values.
            state <= state_d;
            cnt   <= cnt_d;
            Data  <= data_d;
            done  <= done_d;
        end
    end

`ifdef DECODER_PARITY_EN
    // Parity error flag. It pulses for one cycle after a rejected transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err <= 1'b0;
        end else begin
            par_err <= par_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_decoder_hold.sv
// Bench for decoder_hold. Two instances share one set of inputs:
//   dut_a uses the default timing (hold 4, gap 1).
//   dut_b uses hold 1, gap 0.
// For each instance, the reference model keeps only the cycle and Code of the
// last accepted transfer, and the cycle of the last parity rejection.
// Every expected output comes from cycle arithmetic on those values.
module tb_decoder_hold;

    localparam int HA = 4, GA = 1;
    localparam int HB = 1, GB = 0;
`ifdef DECODER_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif
    localparam int NEVER = -1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] Code = 3'd0;
    logic       in_ready_a, busy_a, done_a;
    logic       in_ready_b, busy_b, done_b;
    logic [7:0] data_a, data_b;
`ifdef DECODER_PARITY_EN
    logic       code_par = 1'b0;
    logic       par_err_a, par_err_b;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    // Model state: accept cycle, accepted code and parity-reject cycle for each instance.
    int ta = NEVER, ka = 0, pa = NEVER;
    int tb = NEVER, kb = 0, pb = NEVER;

    decoder_hold dut_a (
        .clk(clk), .rst(rst), .Code(Code), .in_valid(in_valid),
`ifdef DECODER_PARITY_EN
        .code_par(code_par), .par_err(par_err_a),
`endif
        .in_ready(in_ready_a), .Data(data_a), .busy(busy_a), .done(done_a)
    );

    decoder_hold #(.HOLD_CYCLES(HB), .GAP_CYCLES(GB)) dut_b (
        .clk(clk), .rst(rst), .Code(Code), .in_valid(in_valid),
`ifdef DECODER_PARITY_EN
        .code_par(code_par), .par_err(par_err_b),
`endif
        .in_ready(in_ready_b), .Data(data_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        check(tag, {7'd0, obs}, {7'd0, exp});
    endtask

    // Data is one-hot for the h cycles that follow the accept cycle.
    function automatic logic [7:0] exp_data(int t, int k, int h, int c);
        if (c > t && c <= t + h) return 8'd1 << k;
        return 8'd0;
    endfunction

    // The instance is busy from the cycle after an accept until the gap ends.
    function automatic logic exp_busy(int t, int h, int g, int c);
        return (c > t && c <= t + h + g);
    endfunction

    function automatic logic exp_done(int t, int h, int c);
        return (c == t + h + 1);
    endfunction

    task automatic check_outputs();
        check ("a_data", data_a, exp_data(ta, ka, HA, cyc));
        check1("a_done", done_a, exp_done(ta, HA, cyc));
        check1("a_busy", busy_a, exp_busy(ta, HA, GA, cyc));
        check1("a_onehot", ($countones(data_a) <= 1) && !$isunknown(data_a), 1'b1);
        check ("b_data", data_b, exp_data(tb, kb, HB, cyc));
        check1("b_done", done_b, exp_done(tb, HB, cyc));
        check1("b_busy", busy_b, exp_busy(tb, HB, GB, cyc));
        check1("b_onehot", ($countones(data_b) <= 1) && !$isunknown(data_b), 1'b1);
`ifdef DECODER_PARITY_EN
        check1("a_perr", par_err_a, cyc == pa + 1);
        check1("b_perr", par_err_b, cyc == pb + 1);
`endif
    endtask

    // Drive one cycle of inputs, predict the handshake, then advance and check.
    task automatic step(input logic v, input logic [2:0] k, input logic par);
        logic odd, rdy_a, rdy_b;
        in_valid = v;
        Code     = k;
`ifdef DECODER_PARITY_EN
        code_par = par;
`endif
        odd   = PAR_ON && (^{k, par});
        rdy_a = !exp_busy(ta, HA, GA, cyc);
        rdy_b = !exp_busy(tb, HB, GB, cyc);
        #1;
        check1("a_ready", in_ready_a, rdy_a);
        check1("b_ready", in_ready_b, rdy_b);
        if (v && rdy_a) begin
            if (odd) pa = cyc;
            else begin ta = cyc; ka = int'(k); end
        end
        if (v && rdy_b) begin
            if (odd) pb = cyc;
            else begin tb = cyc; kb = int'(k); end
        end
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    // Assert reset mid-cycle, check the asynchronous clear, then release it.
    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        check ("rst_a_data", data_a, 8'h00);
        check ("rst_b_data", data_b, 8'h00);
        check1("rst_a_busy", busy_a, 1'b0);
        check1("rst_a_done", done_a, 1'b0);
        check1("rst_a_ready", in_ready_a, 1'b0);
        check1("rst_b_ready", in_ready_b, 1'b0);
        @(posedge clk);
        #1;
        check1("rst_a_done_edge", done_a, 1'b0);
        check1("rst_b_done_edge", done_b, 1'b0);
        rst = 1'b0;
        cyc = 0;
        ta = NEVER; pa = NEVER;
        tb = NEVER; pb = NEVER;
        #1;
        check1("rel_a_ready", in_ready_a, 1'b1);
        check1("rel_b_ready", in_ready_b, 1'b1);
    endtask

    initial begin
        logic [2:0] k;
        // Reset state while rst is held from time zero.
        #2;
        check ("init_a_data", data_a, 8'h00);
        check1("init_a_busy", busy_a, 1'b0);
        check1("init_a_done", done_a, 1'b0);
        check1("init_a_ready", in_ready_a, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;

        // Code 5 accepted at the end of cycle 10.
        repeat (10) step(1'b0, 3'd0, 1'b0);
        step(1'b1, 3'd5, 1'b0);
        check("t27_data_c11", data_a, 8'h20);
        repeat (3) step(1'b0, 3'd0, 1'b0);
        check("t27_data_c14", data_a, 8'h20);
        step(1'b0, 3'd0, 1'b0);
        check ("t27_data_c15", data_a, 8'h00);
        check1("t27_done_c15", done_a, 1'b1);
        step(1'b0, 3'd0, 1'b0);
        check1("t27_busy_c16", busy_a, 1'b0);
        check1("t27_ready_c16", in_ready_a, 1'b1);

        // Every Code value, one transfer per minimum spacing.
        for (int i = 0; i < 8; i++) begin
            k = 3'(i);
            step(1'b1, k, ^k);
            check("sweep_data", data_a, 8'd1 << i);
            repeat (HA + GA) step(1'b0, 3'd0, 1'b0);
        end

        // Code changes to 3 while Code 1 is still held.
        step(1'b1, 3'd1, 1'b1);
        check("t29_first", data_a, 8'h02);
        repeat (HA - 1) begin
            step(1'b1, 3'd3, 1'b0);
            check("t29_hold", data_a, 8'h02);
        end
        repeat (3) step(1'b1, 3'd3, 1'b0);
        check("t29_next", data_a, 8'h08);

        // in_valid held high. dut_b toggles between one-hot and zero every cycle.
        repeat (24) begin
            k = 3'($urandom_range(0, 7));
            step(1'b1, k, ^k);
        end

        // Reset pulse during HOLD.
        repeat (HA + GA + 1) step(1'b0, 3'd0, 1'b0);
        step(1'b1, 3'd6, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        check("t31_in_hold", data_a, 8'h40);
        reset_pulse();
        step(1'b0, 3'd0, 1'b0);

`ifdef DECODER_PARITY_EN
        // Odd parity is rejected; even parity decodes.
        step(1'b1, 3'b011, 1'b1);
        check1("t32_perr", par_err_a, 1'b1);
        check ("t32_data0", data_a, 8'h00);
        step(1'b0, 3'd0, 1'b0);
        step(1'b1, 3'b011, 1'b0);
        check("t32_data8", data_a, 8'h08);
`endif

        // Random traffic with occasional resets and parity faults.
        repeat (600) begin
            if ($urandom_range(0, 99) == 0) begin
                reset_pulse();
            end else begin
                k = 3'($urandom_range(0, 7));
                step(($urandom_range(0, 3) != 0), k,
                     ($urandom_range(0, 4) == 0) ? ~^k : ^k);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
